// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver; oversampled start validation, mid-bit sampling, byte held for host read.
// Latency: rxd -> rxd_s 2 clk; status pulses on the stop-sample tick (OVERSAMPLE/2 + 9*OVERSAMPLE ticks after start seen).
// Backpressure: none on the line; an unread byte is overwritten by the next good frame and flagged by overrun.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rxd,
    input  logic        rd,
    output logic [31:0] data_out,
    output logic        rx_ready,
    output logic        valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    // Tick counts at which the start bit (half period) and each full bit are sampled.
    localparam logic [3:0] HALF_LAST = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] FULL_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic       rxd_m, rxd_s;
    logic [3:0] tick_cnt, tick_nxt;
    logic [2:0] bit_cnt, bit_nxt;
    logic [7:0] shift, shift_nxt;
    logic       good_done;
    logic       bad_done;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // FSM state and datapath counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
        end
    end

    // Next-state logic; everything advances only on oversample ticks.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        good_done = 1'b0;
        bad_done  = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nxt = START;
                        tick_nxt  = 4'd0;
                    end
                end
                START: begin
                    if (tick_cnt != HALF_LAST) begin
                        tick_nxt = tick_cnt + 4'd1;
                    end else if (!rxd_s) begin
                        state_nxt = DATA;
                        tick_nxt  = 4'd0;
                        bit_nxt   = 3'd0;
                    end else begin
                        // Line went back high before mid-start: treat as noise.
                        state_nxt = IDLE;
                    end
                end
                DATA: begin
                    if (tick_cnt != FULL_LAST) begin
                        tick_nxt = tick_cnt + 4'd1;
                    end else begin
                        shift_nxt = {rxd_s, shift[7:1]};
                        tick_nxt  = 4'd0;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = STOP;
                        end else begin
                            bit_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick_cnt != FULL_LAST) begin
                        tick_nxt = tick_cnt + 4'd1;
                    end else if (rxd_s) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        good_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        bad_done  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so it reports only one framing error.
                    if (rxd_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Registered host-side outputs; status pulses last exactly one clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= 32'd0;
            rx_ready  <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid     <= good_done;
            frame_err <= bad_done;
            overrun   <= good_done && rx_ready && !rd;
            if (good_done) begin
                data_out <= {24'd0, shift};
                rx_ready <= 1'b1;
            end else if (rd) begin
                rx_ready <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: self-checking bench for uart_rx; frames are scheduled as expected events and compared every clk.
// Latency: the model places each stop-sample event 152 ticks after the tick the receiver first sees the start bit.
// Backpressure: host reads are driven directed or at random; the model tracks rx_ready and overrun from them.
`timescale 1ns/1ps
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rxd;
    logic        rd;
    logic [31:0] data_out;
    logic        rx_ready;
    logic        valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .rxd      (rxd),
        .rd       (rd),
        .data_out (data_out),
        .rx_ready (rx_ready),
        .valid    (valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tick;
        bit         good;
        logic [7:0] b;
    } ev_t;

    ev_t        evq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         tick_idx = 0;
    bit         edge_was_tick = 1'b0;
    logic       edge_rd = 1'b0;
    int         nper = 1;
    int         rd_at_tick = -1;
    bit         rd_rand = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_data = 8'd0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         last_valid_cyc = 0;
    int         start_cyc;
    ev_t        ce;
    bit         cev;
    logic       exp_v, exp_f, exp_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edge bookkeeping: which edges were ticks, the tick number, and rd as seen by the edge.
    always @(posedge clk) begin
        cyc           <= cyc + 1;
        edge_was_tick <= enable;
        edge_rd       <= rd;
        if (enable) tick_idx <= tick_idx + 1;
    end

    // Compare process: expected pulses come from the event queue, rx_ready/data_out from the host model.
    always @(negedge clk) begin
        if (!reset) begin
            evq.delete();
            m_ready = 1'b0;
            m_data  = 8'd0;
        end else begin
            cev = 1'b0;
            if (edge_was_tick && evq.size() > 0 && evq[0].tick == tick_idx) begin
                ce  = evq.pop_front();
                cev = 1'b1;
            end
            exp_v = cev && ce.good;
            exp_f = cev && !ce.good;
            exp_o = exp_v && m_ready && !edge_rd;
            chk("valid", {31'd0, valid}, {31'd0, exp_v});
            chk("frame_err", {31'd0, frame_err}, {31'd0, exp_f});
            chk("overrun", {31'd0, overrun}, {31'd0, exp_o});
            if (exp_v) begin
                m_ready = 1'b1;
                m_data  = ce.b;
            end else if (edge_rd) begin
                m_ready = 1'b0;
            end
            chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_ready});
            chk("data_out", data_out, {24'd0, m_data});
            if (valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
        end
    end

    // One line value held for one oversample tick (nper clks, enable on the last).
    task automatic tk(input logic v);
        rxd = v;
        for (int i = 0; i < nper; i++) begin
            enable = (i == nper - 1);
            rd = (enable && (tick_idx + 1 == rd_at_tick)) || (rd_rand && $urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        rd     = 1'b0;
    endtask

    // Serialize one frame and schedule its stop-sample event.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low,
                              input int gap, input bit rd_on_stop);
        int d;
        int t0;
        ev_t e;
        d = (nper >= 3) ? 0 : 3 - nper;
        t0 = tick_idx + 1 + d;
        e.tick = t0 + 152;
        e.good = stop_ok;
        e.b    = b;
        evq.push_back(e);
        if (rd_on_stop) rd_at_tick = t0 + 152;
        repeat (16) tk(1'b0);
        for (int i = 0; i < 8; i++) repeat (16) tk(b[i]);
        repeat (16) tk(stop_ok);
        repeat (extra_low) tk(1'b0);
        repeat (gap) tk(1'b1);
        rd_at_tick = -1;
    endtask

    task automatic do_rd();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic clr_counts();
        n_valid = 0;
        n_ferr  = 0;
        n_ovr   = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        rxd    = 1'b1;
        rd     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        nper  = 1;
        repeat (20) tk(1'b1);

        // Good frame 0xA5 with its stop-sample timing pinned by hand.
        clr_counts();
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 0, 20, 1'b0);
        chk("a5_latency", last_valid_cyc - start_cyc, 155);
        chk("a5_data", data_out, 32'h0000_00A5);
        chk("a5_ready", {31'd0, rx_ready}, 32'd1);
        chk("a5_valid_cnt", n_valid, 1);
        chk("a5_ferr_cnt", n_ferr, 0);
        chk("a5_busy_after", {31'd0, busy}, 32'd0);

        // Glitch of 4 ticks is rejected, then 0x3C is received.
        clr_counts();
        for (int i = 0; i < 11; i++) begin
            tk((i < 4) ? 1'b1 ^ 1'b1 : 1'b1);
            if (i == 2) chk("glitch_busy_at_t0", {31'd0, busy}, 32'd1);
        end
        chk("glitch_idle_by_t0p8", {31'd0, busy}, 32'd0);
        repeat (16) tk(1'b1);
        chk("glitch_no_valid", n_valid, 0);
        send_frame(8'h3C, 1'b1, 0, 20, 1'b0);
        chk("glitch_3c_data", data_out, 32'h0000_003C);

        // Framing error on 0x55 with a long break: one frame_err, held byte untouched.
        clr_counts();
        send_frame(8'h55, 1'b0, 640, 20, 1'b0);
        chk("ferr_cnt", n_ferr, 1);
        chk("ferr_no_valid", n_valid, 0);
        chk("ferr_data_kept", data_out, 32'h0000_003C);
        chk("ferr_ready_kept", {31'd0, rx_ready}, 32'd1);
        do_rd();
        send_frame(8'h81, 1'b1, 0, 20, 1'b0);
        chk("ferr_81_data", data_out, 32'h0000_0081);

        // Back-to-back frames without a read: second one overruns.
        do_rd();
        clr_counts();
        send_frame(8'h11, 1'b1, 0, 0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 20, 1'b0);
        chk("ovr_cnt", n_ovr, 1);
        chk("ovr_valid_cnt", n_valid, 2);
        chk("ovr_data", data_out, 32'h0000_0022);

        // Same again with rd landing on the second completion: no overrun.
        do_rd();
        clr_counts();
        send_frame(8'h11, 1'b1, 0, 0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 20, 1'b1);
        chk("rdovr_cnt", n_ovr, 0);
        chk("rdovr_ready", {31'd0, rx_ready}, 32'd1);

        // Reset during data bit 3 clears every output at once.
        repeat (72) tk(1'b0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_data_out", data_out, 32'd0);
        chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) tk(1'b1);
        send_frame(8'hF0, 1'b1, 0, 20, 1'b0);
        chk("post_rst_f0", data_out, 32'h0000_00F0);

        // Loopback-style stream at one bit per 16 ticks.
        do_rd();
        clr_counts();
        send_frame(8'h00, 1'b1, 0, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 0, 0, 1'b0);
        send_frame(8'h5A, 1'b1, 0, 20, 1'b0);
        chk("loop_valid_cnt", n_valid, 3);
        chk("loop_ferr_cnt", n_ferr, 0);
        chk("loop_data", data_out, 32'h0000_005A);

        // Randomized traffic: tick spacing, bytes, stop errors, glitches, host reads.
        rd_rand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            nper = $urandom_range(1, 4);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 7)) tk(1'b0);
                repeat (10) tk(1'b1);
            end
            if ($urandom_range(0, 5) == 0)
                send_frame(8'($urandom), 1'b0, $urandom_range(0, 40), $urandom_range(2, 20), 1'b0);
            else
                send_frame(8'($urandom), 1'b1, 0, $urandom_range(2, 20), 1'b0);
        end
        rd_rand = 1'b0;
        nper = 1;
        repeat (20) tk(1'b1);
        chk("pending_events", evq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver, the receive-side counterpart of `uart_tx`. It oversamples `rxd` on a clock-enable tick, validates the start bit and samples each bit at mid-bit. It then delivers the byte zero-extended on a 32-bit bus, with a level-held ready flag and single-cycle status pulses. It sits between the pad-side serial input and the host register interface that reads received bytes.

## Interface
- `OVERSAMPLE`, default 16: `enable` ticks per bit period. Must be even, 4 to 16. The tick counter is 4 bits.
- `clk`  in  1  system clock; all flops are rising-edge.
- `reset`  in  1  asynchronous, active-low.
- `enable`  in  1  oversample tick, one `clk` wide, at OVERSAMPLE × baud. The FSM and counters advance only on `clk` edges where `enable`=1.
- `rxd`  in  1  serial input. Asynchronous to `clk`; idles high.
- `rd`  in  1  host read strobe; clears `rx_ready`. Acts on any `clk` edge, not gated by `enable`.
- `data_out`  out  32  last good byte in [7:0]; [31:8] always 0.
- `rx_ready`  out  1  level; a byte is held unread.
- `valid`  out  1  one-`clk` pulse when a good frame completes.
- `frame_err`  out  1  one-`clk` pulse when the stop bit is sampled low.
- `overrun`  out  1  one-`clk` pulse when a good frame completes while `rx_ready`=1 and `rd`=0.
- `busy`  out  1  FSM not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1) clocked every `clk`. The FSM sees only the synchronized `rxd_s`.
- Registers: `tick_cnt` (4b), `bit_cnt` (3b), `shift` (8b), state.
- States: IDLE, START, DATA, STOP, BREAK. All transitions and counter updates occur only on `enable` ticks.
- IDLE: on a tick with `rxd_s`=0, go to START with `tick_cnt`=0.
- START: if `tick_cnt`≠OVERSAMPLE/2−1, increment `tick_cnt`. Otherwise check `rxd_s`:
  - `rxd_s`=0: go to DATA, `tick_cnt`=0, `bit_cnt`=0.
  - `rxd_s`=1: glitch. Return to IDLE with no flags.
- DATA: if `tick_cnt`≠OVERSAMPLE−1, increment `tick_cnt`. Otherwise:
  - shift `rxd_s` in at `shift[7]` (shift right, so LSB first), `tick_cnt`=0;
  - if `bit_cnt`=7 go to STOP, else increment `bit_cnt`.
- STOP: on the tick where `tick_cnt`=OVERSAMPLE−1, check `rxd_s`:
  - `rxd_s`=1: `data_out`←{24'h0,`shift`}, `valid` pulses, `rx_ready`←1; go to IDLE.
  - `rxd_s`=0: `frame_err` pulses; `data_out` and `rx_ready` unchanged; go to BREAK.
- BREAK: stay until a tick with `rxd_s`=1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- `rx_ready` clears on `rd`=1. If `rd` and a good-frame completion occur on the same edge, `rx_ready` stays 1 and `overrun` stays 0.
- On overrun, the new byte overwrites `data_out`.
- `busy` = (state≠IDLE).
- State values outside the five defined states go to IDLE.

## Timing
- Reset values: `data_out`=0, `rx_ready`=0, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, state IDLE, counters 0, `shift`=0.
- Reset asserted mid-frame aborts immediately. Reception resumes at the next falling edge after release.
- Input latency: 2 `clk` from `rxd` to `rxd_s`.
- Let T0 be the tick on which IDLE sees `rxd_s`=0.
  - Start validated at T0+OVERSAMPLE/2.
  - Data bit i sampled at T0+OVERSAMPLE/2+(i+1)·OVERSAMPLE.
  - Stop bit sampled, with `valid`/`frame_err`/`overrun`, at T0+OVERSAMPLE/2+9·OVERSAMPLE. For OVERSAMPLE=16 this is T0+152.
- Status pulses are registered and appear on the same `clk` edge as the stop-sample tick. They deassert on the next `clk`, whether or not `enable` is high.
- The FSM returns to IDLE at mid-stop-bit, so a back-to-back start bit is detected with no lost frame.
- Minimum rejected glitch: low for fewer than OVERSAMPLE/2 ticks.

## Test plan
- Good frame, `enable`=1 every `clk`, OVERSAMPLE=16, byte 0xA5 -> `data_out`=32'h000000A5; `valid` one `clk` at T0+152; `rx_ready`=1; `frame_err`=0; `busy` low after.
- Glitch: `rxd` low for 4 ticks, then high -> no `valid`, FSM back in IDLE by T0+8. A following 0x3C frame is received correctly.
- Framing error: 0x55 sent with stop bit low, then `rxd` held low for 40 bit-times -> exactly one `frame_err`; `data_out` and `rx_ready` unchanged. After `rxd` returns high, 0x81 is received.
- Overrun:
  - 0x11 then 0x22 back-to-back, no `rd` -> second frame gives `valid`+`overrun`, `data_out`=0x22.
  - Repeat with `rd`=1 on the second `valid` edge -> no `overrun`, `rx_ready`=1.
- Reset mid-frame: pull `reset` low during data bit 3 -> all outputs at reset values the same cycle. After release, 0xF0 is received correctly.
- Loopback: `uart_tx` enabled every 16th tick, `rxd`=`txd`, bytes 0x00, 0xFF, 0x5A -> three `valid` pulses with matching `data_out`, no `frame_err`.
